vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter CPU_STARVE_MAX, default 4: number of consecutive arbitration losses to DMA after which CPU outranks DMA.
REQ-002 v_clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 vid_req  in  1  video scanout read request; vid_addr  in  17  byte address.
REQ-005 vid_ack  out  1  one-cycle pulse; rdata valid for video this cycle.
REQ-006 dma_req  in  1; dma_we  in  1; dma_addr  in  17; dma_wdata  in  8  DMA engine access.
REQ-007 dma_ack  out  1  one-cycle completion pulse for DMA.
REQ-008 cpu_req  in  1; cpu_we  in  1; cpu_addr  in  17; cpu_wdata  in  8  CPU access.
REQ-009 cpu_ack  out  1  one-cycle completion pulse for CPU.
REQ-010 rdata  out  8  registered read data, valid only with an ack.
REQ-011 mem_addr  out  17; mem_wdata  out  8; mem_we  out  1; mem_oe  out  1  registered SRAM port.
REQ-012 mem_rdata  in  8  SRAM read data.
REQ-013 gnt_id  out  2  current owner: 0 none, 1 video, 2 DMA, 3 CPU.

Function
REQ-014 FSM states IDLE, ACCESS, ACK; IDLE->ACCESS when any req high at edge; ACCESS->ACK unconditionally; ACK->IDLE unconditionally.
REQ-015 Arbitration only in IDLE; priority video > CPU-if-starved > DMA > CPU.
REQ-016 Latency: req high in cycle N (IDLE) -> mem bus driven cycle N+1 -> ack high cycle N+2; peak throughput one access per 3 cycles.
REQ-017 On IDLE->ACCESS: mem_addr, mem_wdata, mem_we (= winner we; 0 for video), mem_oe (= !we) and gnt_id register winner values.
REQ-018 On ACCESS->ACK: rdata <= mem_rdata for reads (unchanged for writes); winner ack <= 1; mem_we, mem_oe <= 0; mem_addr held.
REQ-019 On ACK->IDLE: all acks <= 0, gnt_id <= 0.
REQ-020 Requester holds req/we/addr/wdata stable from assertion through its ack cycle; arbiter does not latch them beyond ACCESS entry.
REQ-021 Requester drops req during its ack cycle to avoid a repeat grant; a req still high in IDLE is a new request.
REQ-022 Starvation counter, 3-bit saturating: +1 at each IDLE grant to DMA while cpu_req high; cleared on CPU grant or when cpu_req low in IDLE; CPU starved when counter >= CPU_STARVE_MAX.
REQ-023 Video never subject to starvation logic; video grant leaves counter unchanged.
REQ-024 Exactly one ack high in any cycle; acks never asserted outside ACK.
REQ-025 Requests arriving during ACCESS/ACK wait for next IDLE; no request is dropped while held.

Reset
REQ-026 rst high forces immediately: state IDLE, all acks 0, gnt_id 0, mem_we 0, mem_oe 0, mem_addr 0, mem_wdata 0, rdata 0, starvation counter 0.
REQ-027 Reset mid-ACCESS aborts the access with no ack; requester re-requests after release.

Structure
REQ-028 Package vram_arb_pkg holds state enum, requester-ID constants (NONE/VID/DMA/CPU), address width 17, data width 8.
REQ-029 Winner selection in combinational sub-module vram_arb_pick (inputs: three reqs, starved flag; output: ID).

Verification
REQ-030 Single CPU write 0x1ABCD <= 0x5A: mem_we high exactly one cycle at N+1 with that addr/data; cpu_ack at N+2.
REQ-031 Video read 0x03030 with mem_rdata=0xC3: mem_oe high N+1; vid_ack and rdata=0xC3 at N+2.
REQ-032 vid_req, dma_req, cpu_req simultaneous: grant order video, DMA, CPU; acks 3 cycles apart.
REQ-033 DMA and CPU held continuously, STARVE_MAX=4: four DMA grants, then CPU grant, counter back to 0.
REQ-034 rst asserted during ACCESS: outputs zero same cycle, no ack; after release pending req served normally.
REQ-035 Every cycle checks: at most one ack high; mem_we and mem_oe never both high.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: FSM states, requester IDs, bus widths.
package vram_arb_pkg;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    typedef logic [1:0] req_id_t;

    localparam req_id_t ID_NONE = 2'd0;
    localparam req_id_t ID_VID  = 2'd1;
    localparam req_id_t ID_DMA  = 2'd2;
    localparam req_id_t ID_CPU  = 2'd3;
endpackage

// File: rtl/vram_arbiter_if.sv
// Requester and SRAM-side signals of the VRAM arbiter; slave is the arbiter's view.
interface vram_arbiter_if;
    import vram_arb_pkg::*;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ack;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        gnt_id;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_oe;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vid_req, vid_addr,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output vid_ack, dma_ack, cpu_ack, rdata, gnt_id,
        output mem_addr, mem_wdata, mem_we, mem_oe
    );

    modport master (
        output vid_req, vid_addr,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  vid_ack, dma_ack, cpu_ack, rdata, gnt_id,
        input  mem_addr, mem_wdata, mem_we, mem_oe
    );
endinterface

// File: rtl/vram_arb_pick.sv
// Combinational winner select: video first, then a starved CPU, then DMA, then CPU.
module vram_arb_pick
    import vram_arb_pkg::*;
(
    input  logic    vid_req,
    input  logic    dma_req,
    input  logic    cpu_req,
    input  logic    starved,
    output req_id_t id
);
    always_comb begin
        id = ID_NONE;
        if (vid_req)
            id = ID_VID;
        else if (cpu_req && starved)
            id = ID_CPU;
        else if (dma_req)
            id = ID_DMA;
        else if (cpu_req)
            id = ID_CPU;
    end
endmodule

// File: rtl/vram_arbiter.sv
// Three-requester single-port SRAM arbiter, one access per three cycles.
//   state     | meaning
//   ST_IDLE   | arbitrate; register winner onto the SRAM port
//   ST_ACCESS | SRAM port driven, read data captured at end of cycle
//   ST_ACK    | winner's ack pulse, rdata valid for reads
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int CPU_STARVE_MAX = 4
)
(
    input  logic           v_clk,
    input  logic           rst,
    vram_arbiter_if.slave  bus
);
    localparam logic [3:0] STARVE_LIM = 4'(CPU_STARVE_MAX);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        starve_cnt;
    logic              starved;
    req_id_t           winner;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_we;
    logic              any_req;

    assign starved = ({1'b0, starve_cnt} >= STARVE_LIM);
    assign any_req = bus.vid_req | bus.dma_req | bus.cpu_req;

    vram_arb_pick u_pick (
        .vid_req (bus.vid_req),
        .dma_req (bus.dma_req),
        .cpu_req (bus.cpu_req),
        .starved (starved),
        .id      (winner)
    );

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        case (winner)
            ID_VID: win_addr = bus.vid_addr;
            ID_DMA: begin
                win_addr  = bus.dma_addr;
                win_wdata = bus.dma_wdata;
                win_we    = bus.dma_we;
            end
            ID_CPU: begin
                win_addr  = bus.cpu_addr;
                win_wdata = bus.cpu_wdata;
                win_we    = bus.cpu_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge v_clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (any_req) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_ACK;
            ST_ACK:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Video grants leave the count alone; only DMA wins over a waiting CPU advance it.
    always_ff @(posedge v_clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 3'd0;
        end else if (state == ST_IDLE) begin
            if (winner == ID_CPU || !bus.cpu_req)
                starve_cnt <= 3'd0;
            else if (winner == ID_DMA && starve_cnt != 3'd7)
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

    always_ff @(posedge v_clk or posedge rst) begin
        if (rst) begin
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_oe    <= 1'b0;
            bus.gnt_id    <= ID_NONE;
            bus.rdata     <= '0;
            bus.vid_ack   <= 1'b0;
            bus.dma_ack   <= 1'b0;
            bus.cpu_ack   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (winner != ID_NONE) begin
                        bus.mem_addr  <= win_addr;
                        bus.mem_wdata <= win_wdata;
                        bus.mem_we    <= win_we;
                        bus.mem_oe    <= ~win_we;
                        bus.gnt_id    <= winner;
                    end
                end
                ST_ACCESS: begin
                    if (bus.mem_oe)
                        bus.rdata <= bus.mem_rdata;
                    bus.vid_ack <= (bus.gnt_id == ID_VID);
                    bus.dma_ack <= (bus.gnt_id == ID_DMA);
                    bus.cpu_ack <= (bus.gnt_id == ID_CPU);
                    bus.mem_we  <= 1'b0;
                    bus.mem_oe  <= 1'b0;
                end
                ST_ACK: begin
                    bus.vid_ack <= 1'b0;
                    bus.dma_ack <= 1'b0;
                    bus.cpu_ack <= 1'b0;
                    bus.gnt_id  <= ID_NONE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: latency, priority, starvation, reset abort, per-cycle invariants.
module tb_vram_arbiter;
    logic v_clk = 1'b0;
    logic rst   = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic mon_en   = 1'b0;

    vram_arbiter_if bus ();

    vram_arbiter #(.CPU_STARVE_MAX(4)) dut (
        .v_clk (v_clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 v_clk = ~v_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge v_clk);
        #1;
    endtask

    function automatic logic [2:0] acks();
        return {bus.vid_ack, bus.dma_ack, bus.cpu_ack};
    endfunction

    always @(negedge v_clk) begin
        if (mon_en && !rst) begin
            chk("ack_onehot", 32'($countones(acks()) <= 1), 32'd1);
            chk("we_oe_excl", 32'(bus.mem_we & bus.mem_oe), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_gnt [9];
        logic [2:0] exp_ack [9];
        logic       found;
        int         lat;

        bus.vid_req = 0; bus.vid_addr = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mem_rdata = '0;

        // reset state
        step(); step();
        chk("rst_gnt",   32'(bus.gnt_id), 32'd0);
        chk("rst_we_oe", 32'({bus.mem_we, bus.mem_oe}), 32'd0);
        chk("rst_addr",  32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_acks",  32'(acks()), 32'd0);
        rst = 0;
        mon_en = 1;
        step();

        // single CPU write
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 17'h1ABCD; bus.cpu_wdata = 8'h5A;
        step();
        chk("cw_we",    32'(bus.mem_we), 32'd1);
        chk("cw_oe",    32'(bus.mem_oe), 32'd0);
        chk("cw_addr",  32'(bus.mem_addr), 32'h1ABCD);
        chk("cw_wdata", 32'(bus.mem_wdata), 32'h5A);
        chk("cw_gnt",   32'(bus.gnt_id), 32'd3);
        chk("cw_early", 32'(acks()), 32'd0);
        step();
        chk("cw_ack",   32'(acks()), 32'b001);
        chk("cw_we_lo", 32'(bus.mem_we), 32'd0);
        chk("cw_rdata", 32'(bus.rdata), 32'd0);
        bus.cpu_req = 0; bus.cpu_we = 0;
        step();
        chk("cw_ack_clr", 32'(acks()), 32'd0);
        chk("cw_gnt_clr", 32'(bus.gnt_id), 32'd0);
        chk("cw_addr_hold", 32'(bus.mem_addr), 32'h1ABCD);

        // video read
        bus.mem_rdata = 8'hC3; bus.vid_req = 1; bus.vid_addr = 17'h03030;
        step();
        chk("vr_oe",   32'(bus.mem_oe), 32'd1);
        chk("vr_we",   32'(bus.mem_we), 32'd0);
        chk("vr_addr", 32'(bus.mem_addr), 32'h03030);
        chk("vr_gnt",  32'(bus.gnt_id), 32'd1);
        step();
        chk("vr_ack",   32'(acks()), 32'b100);
        chk("vr_rdata", 32'(bus.rdata), 32'hC3);
        bus.vid_req = 0;
        step();

        // all three at once: video, DMA (write), CPU (read)
        exp_gnt = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd0};
        exp_ack = '{3'b000, 3'b100, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b001, 3'b000};
        bus.mem_rdata = 8'h3C;
        bus.vid_req = 1; bus.vid_addr = 17'h00010;
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 17'h00020; bus.dma_wdata = 8'h11;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 17'h00030;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            step();
            chk($sformatf("tri_gnt_c%0d", cyc), 32'(bus.gnt_id), 32'(exp_gnt[cyc-1]));
            chk($sformatf("tri_ack_c%0d", cyc), 32'(acks()), 32'(exp_ack[cyc-1]));
            if (cyc == 2) begin
                chk("tri_vid_rdata", 32'(bus.rdata), 32'h3C);
                bus.vid_req = 0;
            end
            if (cyc == 3) bus.mem_rdata = 8'h96;
            if (cyc == 4) chk("tri_dma_we", 32'(bus.mem_we), 32'd1);
            if (cyc == 5) begin
                chk("tri_wr_keeps_rdata", 32'(bus.rdata), 32'h3C);
                bus.dma_req = 0; bus.dma_we = 0;
            end
            if (cyc == 8) begin
                chk("tri_cpu_rdata", 32'(bus.rdata), 32'h96);
                bus.cpu_req = 0;
            end
        end

        // DMA and CPU held: four DMA grants then CPU, twice over
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 17'h00400;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 17'h00500; bus.cpu_wdata = 8'hA5;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("stv_gnt_%0d", k), 32'(bus.gnt_id), (k % 5 == 4) ? 32'd3 : 32'd2);
            step();
            chk($sformatf("stv_ack_%0d", k), 32'(acks()), (k % 5 == 4) ? 32'b001 : 32'b010);
            if (k == 9) begin
                bus.dma_req = 0; bus.cpu_req = 0; bus.cpu_we = 0;
            end
            step();
            chk($sformatf("stv_idle_%0d", k), 32'(bus.gnt_id), 32'd0);
        end

        // reset during ACCESS aborts, then the held request is served
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 17'h00123; bus.dma_wdata = 8'h77;
        step();
        chk("ra_we_pre", 32'(bus.mem_we), 32'd1);
        rst = 1;
        #1;
        chk("ra_we",    32'(bus.mem_we), 32'd0);
        chk("ra_addr",  32'(bus.mem_addr), 32'd0);
        chk("ra_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("ra_gnt",   32'(bus.gnt_id), 32'd0);
        step();
        chk("ra_no_ack", 32'(acks()), 32'd0);
        rst = 0;
        found = 0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            if (!found) begin
                step();
                if (bus.dma_ack) begin
                    found = 1;
                    lat = i;
                end
            end
        end
        chk("ra_retry_lat", 32'(lat), 32'd2);
        chk("ra_retry_addr", 32'(bus.mem_addr), 32'h00123);
        bus.dma_req = 0; bus.dma_we = 0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
